req_pend_ctrl: RTL and testbench



---
 rtl/req_pend_ctrl_pkg.sv | 22 ++
 rtl/req_pend_ctrl_if.sv | 28 ++
 rtl/req_pend_ctrl_capture.sv | 51 +++++
 rtl/req_pend_ctrl.sv | 82 ++++++++
 tb/tb_req_pend_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/req_pend_ctrl_pkg.sv
// Shared types and sizes for the request-pending controller.
// Optional build macro used by this block: REQ_EDGE_EN (edge-triggered capture).
`timescale 1ns/1ps
package req_pend_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } svc_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    // One-hot vector selecting a single request line
    function automatic req_vec_t idx_to_onehot(input req_idx_t idx);
        return req_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/req_pend_ctrl_if.sv
// Bus bundle between the request controller, the priority encoder and the consumer.
// slave: the controller's view. master: the surrounding logic's view.
`timescale 1ns/1ps
interface req_pend_ctrl_if;
    import req_pend_pkg::*;

    req_vec_t req_in;
    req_vec_t mask;
    req_vec_t pend_out;
    req_idx_t enc_y;
    logic     enc_valid;
    logic     svc_req;
    req_idx_t svc_idx;
    logic     svc_ack;
    req_vec_t ovf;
    logic     ovf_clr;

    modport slave (
        input  req_in, mask, enc_y, enc_valid, svc_ack, ovf_clr,
        output pend_out, svc_req, svc_idx, ovf
    );

    modport master (
        output req_in, mask, enc_y, enc_valid, svc_ack, ovf_clr,
        input  pend_out, svc_req, svc_idx, ovf
    );

endinterface

// File: rtl/req_pend_ctrl_capture.sv
// Request capture, sticky pending register and overflow flags.
// REQ_EDGE_EN selects rising-edge capture; the default is level capture.
`timescale 1ns/1ps
module req_capture
    import req_pend_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  req_vec_t req_in,
    input  req_vec_t mask,
    input  logic     clr_en,
    input  req_idx_t clr_idx,
    input  logic     ovf_clr,
    output req_vec_t pend,
    output req_vec_t ovf
);

    req_vec_t cap;
    req_vec_t clr_vec;
    req_vec_t ovf_set;

`ifdef REQ_EDGE_EN
    req_vec_t req_q;

    // Previous request levels, for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) req_q <= '0;
        else        req_q <= req_in;
    end

    assign cap = req_in & ~req_q & ~mask;
`else
    assign cap = req_in & ~mask;
`endif

    assign clr_vec = clr_en ? idx_to_onehot(clr_idx) : '0;
    // A re-request on the line being cleared is a fresh request, not an overflow
    assign ovf_set = cap & pend & ~clr_vec;

    // Pending and overflow registers; set wins over clear on the same bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            pend <= (pend & ~clr_vec) | cap;
            ovf  <= (ovf_clr ? '0 : ovf) | ovf_set;
        end
    end

endmodule

// File: rtl/req_pend_ctrl.sv
// Request-pending controller: feeds pending bits to the external encoder and
// grants one service request at a time over a req/ack handshake.
// Optional build macro: REQ_EDGE_EN (see req_capture).
//
//   state    | meaning
//   IDLE     | no grant outstanding; waiting for a valid, still-pending encoder pick
//   WAIT_ACK | svc_req high, svc_idx frozen; waiting for svc_ack
`timescale 1ns/1ps
module req_pend_ctrl
    import req_pend_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    req_pend_ctrl_if.slave bus
);

    svc_state_t state, state_nxt;
    logic       svc_req, svc_req_nxt;
    req_idx_t   svc_idx, svc_idx_nxt;
    logic       ack_take;
    req_vec_t   pend;

    // Ack only counts while a grant is outstanding
    assign ack_take = (state == WAIT_ACK) && bus.svc_ack;

    req_capture u_capture (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (bus.req_in),
        .mask    (bus.mask),
        .clr_en  (ack_take),
        .clr_idx (svc_idx),
        .ovf_clr (bus.ovf_clr),
        .pend    (pend),
        .ovf     (bus.ovf)
    );

    // State and service-output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            svc_req <= 1'b0;
            svc_idx <= '0;
        end else begin
            state   <= state_nxt;
            svc_req <= svc_req_nxt;
            svc_idx <= svc_idx_nxt;
        end
    end

    // Grant/ack sequencing; encoder pick is checked against pend so a stale
    // or mismatched encoder output is never granted
    always_comb begin
        state_nxt   = state;
        svc_req_nxt = svc_req;
        svc_idx_nxt = svc_idx;
        unique case (state)
            IDLE: begin
                if (bus.enc_valid && pend[bus.enc_y]) begin
                    svc_idx_nxt = bus.enc_y;
                    svc_req_nxt = 1'b1;
                    state_nxt   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.svc_ack) begin
                    svc_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                svc_req_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    assign bus.pend_out = pend;
    assign bus.svc_req  = svc_req;
    assign bus.svc_idx  = svc_idx;

endmodule

// File: tb/tb_req_pend_ctrl.sv
// Directed bench for req_pend_ctrl with a highest-bit-wins encoder model.
`timescale 1ns/1ps
module tb_req_pend_ctrl;
    import req_pend_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    req_pend_ctrl_if bus ();

    req_pend_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder model: highest set bit of A wins, valid = |A
    always_comb begin
        bus.enc_y     = 2'd0;
        bus.enc_valid = |bus.pend_out;
        for (int i = 0; i < N_REQ; i++)
            if (bus.pend_out[i]) bus.enc_y = 2'(i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.req_in  = 4'hF;
        bus.mask    = 4'h0;
        bus.svc_ack = 1'b0;
        bus.ovf_clr = 1'b0;

        // 1. reset with all requests high
        tick();
        tick();
        chk("rst_pend", 8'(bus.pend_out), 8'h0);
        chk("rst_req",  8'(bus.svc_req),  8'h0);
        chk("rst_idx",  8'(bus.svc_idx),  8'h0);
        chk("rst_ovf",  8'(bus.ovf),      8'h0);
        rst_n = 1'b1;
        tick();
        chk("rel_pend", 8'(bus.pend_out), 8'hF);
        chk("rel_req0", 8'(bus.svc_req),  8'h0);
        bus.req_in = 4'h0;
        tick();
        chk("rel_req1", 8'(bus.svc_req), 8'h1);
        chk("rel_idx",  8'(bus.svc_idx), 8'h3);
        chk("rel_ovf",  8'(bus.ovf),     8'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // 2. single request, ack three cycles after grant
        bus.req_in = 4'b0100;
        tick();
        bus.req_in = 4'b0000;
        tick();
        chk("s_req",  8'(bus.svc_req), 8'h1);
        chk("s_idx",  8'(bus.svc_idx), 8'h2);
        tick();
        tick();
        chk("s_hold_req", 8'(bus.svc_req), 8'h1);
        chk("s_hold_idx", 8'(bus.svc_idx), 8'h2);
        bus.svc_ack = 1'b1;
        tick();
        bus.svc_ack = 1'b0;
        chk("s_ack_req",  8'(bus.svc_req),  8'h0);
        chk("s_ack_pend", 8'(bus.pend_out), 8'h0);
        tick();
        chk("s_idle_req", 8'(bus.svc_req), 8'h0);

        // 3. back-to-back grants
        bus.req_in = 4'b1010;
        tick();
        bus.req_in = 4'b0000;
        chk("b_pend0", 8'(bus.pend_out), 8'hA);
        tick();
        chk("b_req0", 8'(bus.svc_req), 8'h1);
        chk("b_idx0", 8'(bus.svc_idx), 8'h3);
        bus.svc_ack = 1'b1;
        tick();
        bus.svc_ack = 1'b0;
        chk("b_gap",   8'(bus.svc_req),  8'h0);
        chk("b_pend1", 8'(bus.pend_out), 8'h2);
        tick();
        chk("b_req1", 8'(bus.svc_req), 8'h1);
        chk("b_idx1", 8'(bus.svc_idx), 8'h1);
        bus.svc_ack = 1'b1;
        tick();
        bus.svc_ack = 1'b0;
        chk("b_req2",  8'(bus.svc_req),  8'h0);
        chk("b_pend2", 8'(bus.pend_out), 8'h0);

        // 4. set/clear collision on line 3
        bus.req_in = 4'b1000;
        tick();
        bus.req_in = 4'b0000;
        tick();
        chk("c_idx0", 8'(bus.svc_idx), 8'h3);
        bus.req_in  = 4'b1000;
        bus.svc_ack = 1'b1;
        tick();
        bus.req_in  = 4'b0000;
        bus.svc_ack = 1'b0;
        chk("c_pend", 8'(bus.pend_out), 8'h8);
        chk("c_req",  8'(bus.svc_req),  8'h0);
        chk("c_ovf",  8'(bus.ovf),      8'h0);
        tick();
        chk("c_req1", 8'(bus.svc_req), 8'h1);
        chk("c_idx1", 8'(bus.svc_idx), 8'h3);
        bus.svc_ack = 1'b1;
        tick();
        bus.svc_ack = 1'b0;
        chk("c_pend1", 8'(bus.pend_out), 8'h0);

        // 5. mask and overflow on line 0
        bus.mask   = 4'b0001;
        bus.req_in = 4'b0001;
        tick();
        tick();
        chk("m_pend", 8'(bus.pend_out), 8'h0);
        chk("m_req",  8'(bus.svc_req),  8'h0);
        bus.mask = 4'b0000;
        tick();
        tick();
        tick();
        bus.req_in = 4'b0000;
`ifdef REQ_EDGE_EN
        chk("o_ovf_set", 8'(bus.ovf),     8'h0);
        chk("o_req",     8'(bus.svc_req), 8'h0);
`else
        chk("o_ovf_set", 8'(bus.ovf),     8'h1);
        chk("o_req",     8'(bus.svc_req), 8'h1);
        chk("o_idx",     8'(bus.svc_idx), 8'h0);
`endif
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("o_ovf_clr", 8'(bus.ovf), 8'h0);
        bus.svc_ack = 1'b1;
        tick();
        bus.svc_ack = 1'b0;
        chk("o_pend", 8'(bus.pend_out), 8'h0);

        // 6. reset while a grant is outstanding, then a late ack
        bus.req_in = 4'b0001;
        tick();
        bus.req_in = 4'b0000;
        tick();
        chk("r_req_pre", 8'(bus.svc_req), 8'h1);
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        bus.svc_ack = 1'b1;
        tick();
        bus.svc_ack = 1'b0;
        chk("r_req",  8'(bus.svc_req),  8'h0);
        chk("r_pend", 8'(bus.pend_out), 8'h0);
        tick();
        chk("r_req2", 8'(bus.svc_req), 8'h0);
`ifdef REQ_EDGE_EN
        bus.req_in = 4'b0001;
        tick();
        tick();
        chk("e_req", 8'(bus.svc_req), 8'h1);
        bus.svc_ack = 1'b1;
        tick();
        bus.svc_ack = 1'b0;
        tick();
        tick();
        chk("e_req_once", 8'(bus.svc_req),  8'h0);
        chk("e_pend",     8'(bus.pend_out), 8'h0);
        chk("e_ovf",      8'(bus.ovf),      8'h0);
        bus.req_in = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
